// File: rtl/kernel_kcore_start_pkg.sv
// Shared types and sizing for the kcore start-token arbiter.
// Default sizing covers the four dataflow producers of the kcore kernel.
package kernel_kcore_start_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam int KCORE_NUM_REQ  = 4;
  localparam int KCORE_ID_WIDTH = $clog2(KCORE_NUM_REQ);
  localparam int KCORE_MAX_OUT  = 4;
  localparam int KCORE_CNT_W    = $clog2(KCORE_MAX_OUT + 1);

endpackage

// File: rtl/kernel_kcore_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last_grant+1, wrapping.
// Zero latency, no state; found=0 when no request is set.
module kernel_kcore_rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic                found,
  output logic [ID_WIDTH-1:0] index
);

  int k;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    k     = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = (int'(last_grant) + i) % NUM_REQ;
      if (req[k]) begin
        found = 1'b1;
        index = ID_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/kernel_kcore_start_token_arb.sv
// Round-robin start-token arbiter: grant latched in IDLE, token pushed from WRITE (1-cycle latency, 1 token / 2 cycles).
// Holds WRITE with stable fifo_din while fifo_full_n is low; stops granting once MAX_OUTSTANDING tokens are unretired.
module kernel_kcore_start_token_arb
  import kernel_kcore_start_pkg::*;
#(
  parameter int NUM_REQ         = KCORE_NUM_REQ,
  parameter int ID_WIDTH        = KCORE_ID_WIDTH,
  parameter int MAX_OUTSTANDING = KCORE_MAX_OUT,
  parameter int CNT_WIDTH       = KCORE_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ack,
  input  logic                 fifo_full_n,
  output logic                 fifo_write,
  output logic [ID_WIDTH-1:0]  fifo_din,
  input  logic                 done_in,
  output logic [CNT_WIDTH-1:0] outstanding,
  output logic                 idle,
  output logic                 err_underflow
);

  state_t              state;
  logic [ID_WIDTH-1:0] last_grant;
  logic                pick_found;
  logic [ID_WIDTH-1:0] pick_idx;
  logic                accept;

  kernel_kcore_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .found      (pick_found),
    .index      (pick_idx)
  );

  // fifo_din doubles as the committed grant while in WRITE.
  assign accept  = (state == WRITE) && fifo_full_n && !reset;
  assign req_ack = accept ? (NUM_REQ'(1) << fifo_din) : '0;
  assign idle    = (state == IDLE) && (outstanding == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= ID_WIDTH'(NUM_REQ - 1);
      outstanding   <= '0;
      fifo_write    <= 1'b0;
      fifo_din      <= '0;
      err_underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found && (outstanding < CNT_WIDTH'(MAX_OUTSTANDING))) begin
            fifo_din   <= pick_idx;
            fifo_write <= 1'b1;
            state      <= WRITE;
          end
        end
        WRITE: begin
          if (fifo_full_n) begin
            last_grant <= fifo_din;
            fifo_write <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A push and a retire in the same cycle cancel out.
      if (accept && !done_in) begin
        outstanding <= outstanding + 1'b1;
      end else if (!accept && done_in) begin
        if (outstanding == '0) err_underflow <= 1'b1;
        else                   outstanding   <= outstanding - 1'b1;
      end
    end
  end

endmodule

// File: doc/kernel_kcore_start_token_arb.md
# kernel_kcore_start_token_arb

Round-robin scheduler that shares one start-token FIFO write port among NUM_REQ dataflow producer processes in the kcore kernel. Each granted producer's ID is pushed as one token into the shared start FIFO toward the write-back stage. A credit counter caps tokens outstanding at the consumer, incremented on push and decremented on the consumer's done pulse. Sits between the producer processes' start handshakes and the start FIFO's write side.

## Interface
- NUM_REQ, 4, number of requesting producers (2..16)
- ID_WIDTH, 2, width of token payload; equals $clog2(NUM_REQ) and the FIFO DATA_WIDTH
- MAX_OUTSTANDING, 4, maximum tokens issued but not yet retired by done_in
- CNT_WIDTH, 3, width of outstanding counter; equals $clog2(MAX_OUTSTANDING+1)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-producer start request; level, held until acked
- req_ack  out  NUM_REQ  one-hot pulse, token of that producer accepted by FIFO this cycle
- fifo_full_n  in  1  FIFO write-side not-full
- fifo_write  out  1  FIFO write strobe (FIFO write_ce tied high)
- fifo_din  out  ID_WIDTH  index of granted producer
- done_in  in  1  consumer retired one token (single-cycle pulse)
- outstanding  out  CNT_WIDTH  tokens issued, not retired
- idle  out  1  FSM in IDLE and outstanding == 0
- err_underflow  out  1  sticky: done_in seen with outstanding == 0

## Operation
- FSM states: IDLE, WRITE.
- IDLE: if any req_valid and outstanding < MAX_OUTSTANDING, latch grant = first set bit searching upward (with wrap) from last_grant+1; go WRITE. Else stay.
- WRITE: fifo_write = 1, fifo_din = grant (registered). If fifo_full_n = 1: req_ack[grant] = 1, outstanding += 1, last_grant <= grant, go IDLE. If fifo_full_n = 0: hold WRITE, fifo_din stable, no ack.
- Grant is committed in WRITE; req_valid changes of other producers do not re-arbitrate. Requester dropping req_valid in WRITE is a protocol violation; token is still written.
- Counter: accept and done_in same cycle -> unchanged. done_in at 0 -> counter stays 0, err_underflow <= 1 (cleared only by reset).
- Credit check uses the registered outstanding value; a same-cycle done_in does not open a credit until next cycle.
- No fairness starvation: any continuously asserted requester is granted within NUM_REQ grants.

## Timing
- Reset values: state IDLE, last_grant = NUM_REQ-1 (req 0 highest priority first), outstanding 0, fifo_write 0, fifo_din 0, req_ack 0, err_underflow 0, idle 1.
- Latency: req_valid sampled in IDLE at cycle t -> fifo_write high at t+1; with fifo_full_n high, req_ack and FIFO push at t+1.
- Throughput: one token per 2 cycles maximum.
- fifo_write, fifo_din are registered; req_ack = (state==WRITE) & fifo_full_n & onehot(grant).
- Reset in WRITE: token not pushed, no ack, requester must keep req_valid; outstanding forced to 0.

## Structure
- Package kernel_kcore_start_pkg: FSM state enum (IDLE, WRITE), ID-width helper constant.
- Sub-module kernel_kcore_rr_pick: combinational round-robin picker (req vector, last_grant -> found, index). All state in top.

## Test plan
- Reset then req_valid=4'b0001, fifo_full_n=1 -> fifo_write at cycle 2, fifo_din=0, req_ack=4'b0001, outstanding=1.
- req_valid=4'b1111 held, done_in pulsed each ack, full_n=1 -> fifo_din sequence 0,1,2,3,0, one ack per 2 cycles.
- fifo_full_n=0 for 5 cycles during WRITE with grant 2 -> fifo_write held, fifo_din=2 stable, no ack; ack on first full_n=1 cycle.
- No done_in, req_valid=4'b0001 held -> exactly 4 acks, outstanding=4, no further fifo_write; one done_in -> fifth ack 2 cycles later.
- Accept and done_in same cycle at outstanding=2 -> stays 2; done_in at outstanding=0 -> err_underflow=1, counter 0.
- Reset asserted in WRITE -> next cycle fifo_write=0, req_ack=0, outstanding=0, idle=1.
